// File: rtl/beep_scheduler_pkg.sv
// Shared types and constants for the piezo beep scheduler: FSM state encoding,
// active-source codes and the tone divider constant.
package beep_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEY    = 3'd1,
    ST_CH_ON  = 3'd2,
    ST_CH_OFF = 3'd3,
    ST_AL_ON  = 3'd4,
    ST_AL_OFF = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_KEY   = 2'd1,
    SRC_CHIME = 2'd2,
    SRC_ALARM = 2'd3
  } src_t;

  // Half period of the 500 Hz tone in clk_1khz cycles.
  localparam int unsigned TONE_HALF_MS = 1;
  localparam int unsigned MS_W         = 10;

  function automatic src_t src_of(input state_t s);
    case (s)
      ST_KEY:              return SRC_KEY;
      ST_CH_ON, ST_CH_OFF: return SRC_CHIME;
      ST_AL_ON, ST_AL_OFF: return SRC_ALARM;
      default:             return SRC_NONE;
    endcase
  endfunction

  function automatic logic is_tone_state(input state_t s);
    return (s == ST_KEY) || (s == ST_CH_ON) || (s == ST_AL_ON);
  endfunction

endpackage

// File: rtl/beep_phase_timer.sv
// Millisecond phase timer: counts enabled cycles from a clear and flags the
// last cycle of a phase whose length is given by term.
module beep_phase_timer
  import beep_scheduler_pkg::*;
#(
  parameter int unsigned W = MS_W
) (
  input  logic         clk_1khz,
  input  logic         switch_clr,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         done
);

  logic [W-1:0] ms_cnt;

  // done marks the final cycle, so the count never passes term-1 or wraps.
  assign done = (ms_cnt == term - W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      ms_cnt <= '0;
    end else if (clr) begin
      ms_cnt <= '0;
    end else if (en && !done) begin
      ms_cnt <= ms_cnt + W'(1);
    end
  end

endmodule

// File: rtl/beep_scheduler.sv
// Piezo owner: arbitrates key click, chime and alarm with alarm > chime > key
// priority, sequences each on/off pattern and drives a registered 500 Hz beep.
module beep_scheduler
  import beep_scheduler_pkg::*;
#(
  parameter int unsigned KEY_MS      = 50,
  parameter int unsigned ON_MS       = 100,
  parameter int unsigned OFF_MS      = 100,
  parameter int unsigned CHIME_BEEPS = 3,
  parameter int unsigned ALARM_SEC   = 30
) (
  input  logic       clk_1khz,
  input  logic       switch_clr,
  input  logic       tick_1hz,
  input  logic       req_key,
  input  logic       req_chime,
  input  logic       req_alarm,
  input  logic       alarm_ack,
  input  logic       debug_force,
  output logic       beep,
  output logic [1:0] active_src,
  output logic       busy
);

  state_t            state, state_nxt;
  logic              enter;
  logic [3:0]        burst_cnt, burst_nxt;
  logic [5:0]        sec_cnt, sec_nxt;
  logic              chime_pend, pend_nxt;
  logic              alarm_prev;
  logic              alarm_rise;
  logic              in_alarm;
  logic              alarm_exit;
  logic              tone, tone_nxt;
  logic [3:0]        dbg_div;
  logic              dbg_tog;
  logic [MS_W-1:0]   term;
  logic              phase_done;

  beep_phase_timer #(.W(MS_W)) u_timer (
    .clk_1khz   (clk_1khz),
    .switch_clr (switch_clr),
    .clr        (enter),
    .en         (state != ST_IDLE),
    .term       (term),
    .done       (phase_done)
  );

  always_comb begin
    case (state)
      ST_KEY:              term = MS_W'(KEY_MS);
      ST_CH_OFF, ST_AL_OFF: term = MS_W'(OFF_MS);
      default:             term = MS_W'(ON_MS);
    endcase
  end

  assign alarm_rise = req_alarm & ~alarm_prev;
  assign in_alarm   = (state == ST_AL_ON) || (state == ST_AL_OFF);
  // Ack beats a simultaneous rise; a timeout yields to a fresh rise.
  assign alarm_exit = in_alarm &&
                      (alarm_ack ||
                       (!alarm_rise && tick_1hz && sec_cnt == 6'(ALARM_SEC - 1)));

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    enter     = 1'b0;
    burst_nxt = burst_cnt;
    sec_nxt   = sec_cnt;
    pend_nxt  = chime_pend;
    if (alarm_exit) begin
      enter   = 1'b1;
      sec_nxt = '0;
      if (chime_pend || req_chime) begin
        state_nxt = ST_CH_ON;
        burst_nxt = '0;
        pend_nxt  = 1'b0;
      end else begin
        state_nxt = ST_IDLE;
      end
    end else if (alarm_rise) begin
      state_nxt = ST_AL_ON;
      enter     = 1'b1;
      burst_nxt = '0;
      sec_nxt   = '0;
      if (state == ST_CH_ON || state == ST_CH_OFF || req_chime) pend_nxt = 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_KEY: begin
          if (req_chime) begin
            state_nxt = ST_CH_ON;
            enter     = 1'b1;
            burst_nxt = '0;
          end else if (state == ST_IDLE && req_key) begin
            state_nxt = ST_KEY;
            enter     = 1'b1;
          end else if (state == ST_KEY && phase_done) begin
            state_nxt = ST_IDLE;
            enter     = 1'b1;
          end
        end
        ST_CH_ON: begin
          if (phase_done) begin
            state_nxt = ST_CH_OFF;
            enter     = 1'b1;
            burst_nxt = burst_cnt + 4'd1;
          end
        end
        ST_CH_OFF: begin
          if (phase_done) begin
            enter     = 1'b1;
            state_nxt = (burst_cnt == 4'(CHIME_BEEPS)) ? ST_IDLE : ST_CH_ON;
          end
        end
        ST_AL_ON, ST_AL_OFF: begin
          if (req_chime) pend_nxt = 1'b1;
          if (tick_1hz)  sec_nxt  = sec_cnt + 6'd1;
          if (phase_done) begin
            enter     = 1'b1;
            state_nxt = (state == ST_AL_ON) ? ST_AL_OFF : ST_AL_ON;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          enter     = 1'b1;
        end
      endcase
    end

    // Tone restarts high on every entry into a sounding phase.
    if (is_tone_state(state_nxt)) tone_nxt = enter ? 1'b1 : ~tone;
    else                          tone_nxt = 1'b0;
  end

  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      state      <= ST_IDLE;
      burst_cnt  <= '0;
      sec_cnt    <= '0;
      chime_pend <= 1'b0;
      alarm_prev <= 1'b0;
      tone       <= 1'b0;
    end else begin
      state      <= state_nxt;
      burst_cnt  <= burst_nxt;
      sec_cnt    <= sec_nxt;
      chime_pend <= pend_nxt;
      alarm_prev <= req_alarm;
      tone       <= tone_nxt;
    end
  end

  // Free-running 500 Hz source for the debug path, independent of the FSM.
  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      dbg_div <= '0;
      dbg_tog <= 1'b0;
    end else if (dbg_div == 4'(TONE_HALF_MS - 1)) begin
      dbg_div <= '0;
      dbg_tog <= ~dbg_tog;
    end else begin
      dbg_div <= dbg_div + 4'd1;
    end
  end

  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      beep       <= 1'b0;
      active_src <= SRC_NONE;
      busy       <= 1'b0;
    end else begin
      beep       <= tone | (debug_force & dbg_tog);
      active_src <= src_of(state);
      busy       <= (state != ST_IDLE);
    end
  end

endmodule
